mips_cpu_axi_bridge: RTL and testbench

MIPS_CPU_AXI_BRIDGE -- requirements
Module: mips_cpu_axi_bridge

---
 rtl/mips_cpu_bridge_pkg.sv | 25 ++
 rtl/mips_cpu_rst_sync.sv | 25 ++
 rtl/mips_cpu_axi_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_mips_cpu_axi_bridge.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_bridge_pkg.sv
// Shared types and constants for the MIPS CPU AXI-Lite bridge.
// Register map: CTRL at 0x0, CYCLE at 0x4 (present only with MIPS_CPU_AXI_BRIDGE_PERF_CNT_EN).
package mips_cpu_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_RESP = 2'd1,
        RD_WAIT = 2'd2,
        RD_RESP = 2'd3
    } bridge_state_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam logic [31:0] REG_CTRL    = 32'h0000_0000;
    localparam logic [31:0] REG_CYCLE   = 32'h0000_0004;

    // Register offsets decode on word granularity; byte lanes within a word alias.
    function automatic logic reg_mapped(input logic [31:0] ofs, input logic cycle_en);
        logic [31:0] aligned;
        aligned = ofs & ~32'h3;
        return (aligned == REG_CTRL) || (cycle_en && (aligned == REG_CYCLE));
    endfunction

endpackage

// File: rtl/mips_cpu_rst_sync.sv
// Two-flop chain producing the active-low MIPS core reset from CTRL.core_rst.
// Both flops clear on bridge reset, so the core is held in reset until software releases it.
module mips_cpu_rst_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_core_rst,
    output logic o_core_reset_n
);

    logic r_stage1;
    logic r_stage2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage1 <= 1'b0;
            r_stage2 <= 1'b0;
        end else begin
            r_stage1 <= ~i_core_rst;
            r_stage2 <= r_stage1;
        end
    end

    assign o_core_reset_n = r_stage2;

endmodule

// File: rtl/mips_cpu_axi_bridge.sv
// AXI-Lite slave bridging host accesses to MIPS CPU memory and a small control register file.
// Optional CYCLE counter register enabled by defining MIPS_CPU_AXI_BRIDGE_PERF_CNT_EN.
module mips_cpu_axi_bridge
    import mips_cpu_bridge_pkg::*;
#(
    parameter int ADDR_W        = 14,
    parameter bit CORE_RST_INIT = 1'b1
) (
    input  logic              mips_cpu_clk,
    input  logic              mips_cpu_reset_n,

    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,

    output logic [ADDR_W-4:0] mem_addr,
    output logic              mem_wen,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    output logic              mem_ren,
    input  logic [31:0]       mem_rdata,

    output logic              core_reset_n
);

`ifdef MIPS_CPU_AXI_BRIDGE_PERF_CNT_EN
    localparam bit CYCLE_EN = 1'b1;
`else
    localparam bit CYCLE_EN = 1'b0;
`endif

    bridge_state_e r_state;
    bridge_state_e w_state_nxt;

    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_aw_is_mem;
    logic          w_ar_is_mem;
    logic [31:0]   w_aw_ofs;
    logic [31:0]   w_ar_ofs;
    logic [31:0]   w_reg_rdata;

    logic          r_core_rst;
    logic          r_rd_mem;
    logic [31:0]   r_rd_ofs;
    logic [31:0]   r_rdata;
    logic [1:0]    r_rresp;
    logic [1:0]    r_bresp;

    assign w_aw_is_mem = ~s_awaddr[ADDR_W-1];
    assign w_ar_is_mem = ~s_araddr[ADDR_W-1];
    assign w_aw_ofs    = 32'(s_awaddr[ADDR_W-2:0]);
    assign w_ar_ofs    = 32'(s_araddr[ADDR_W-2:0]);

    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
        if (!mips_cpu_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Readies are combinational pulses; the reset qualifier keeps them low while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_acc    = 1'b0;
        w_rd_acc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (mips_cpu_reset_n) begin
                    if (s_awvalid && s_wvalid) begin
                        w_wr_acc    = 1'b1;
                        w_state_nxt = WR_RESP;
                    end else if (s_arvalid) begin
                        w_rd_acc    = 1'b1;
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            WR_RESP: begin
                if (s_bready) begin
                    w_state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                w_state_nxt = RD_RESP;
            end
            RD_RESP: begin
                if (s_rready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign s_awready = w_wr_acc;
    assign s_wready  = w_wr_acc;
    assign s_arready = w_rd_acc;
    assign s_bvalid  = (r_state == WR_RESP);
    assign s_rvalid  = (r_state == RD_RESP);
    assign s_bresp   = r_bresp;
    assign s_rresp   = r_rresp;
    assign s_rdata   = r_rdata;

    assign mem_wen   = w_wr_acc & w_aw_is_mem;
    assign mem_ren   = w_rd_acc & w_ar_is_mem;
    assign mem_addr  = w_wr_acc ? s_awaddr[ADDR_W-2:2] : s_araddr[ADDR_W-2:2];
    assign mem_wstrb = s_wstrb;
    assign mem_wdata = s_wdata;

`ifdef MIPS_CPU_AXI_BRIDGE_PERF_CNT_EN
    logic [31:0] r_cycle;

    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
        if (!mips_cpu_reset_n) begin
            r_cycle <= '0;
        end else if (!core_reset_n) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`endif

    always_comb begin
        w_reg_rdata = '0;
        if ((r_rd_ofs & ~32'h3) == REG_CTRL) begin
            w_reg_rdata = {31'b0, r_core_rst};
        end
`ifdef MIPS_CPU_AXI_BRIDGE_PERF_CNT_EN
        if ((r_rd_ofs & ~32'h3) == REG_CYCLE) begin
            w_reg_rdata = r_cycle;
        end
`endif
    end

    always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
        if (!mips_cpu_reset_n) begin
            r_core_rst <= CORE_RST_INIT;
            r_bresp    <= RESP_OKAY;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_rd_mem   <= 1'b0;
            r_rd_ofs   <= '0;
        end else begin
            if (w_wr_acc) begin
                if (w_aw_is_mem || reg_mapped(w_aw_ofs, CYCLE_EN)) begin
                    r_bresp <= RESP_OKAY;
                end else begin
                    r_bresp <= RESP_SLVERR;
                end
                if (!w_aw_is_mem && ((w_aw_ofs & ~32'h3) == REG_CTRL) && s_wstrb[0]) begin
                    r_core_rst <= s_wdata[0];
                end
            end
            if (w_rd_acc) begin
                r_rd_mem <= w_ar_is_mem;
                r_rd_ofs <= w_ar_ofs;
            end
            // mem_rdata is valid exactly in RD_WAIT, one cycle after mem_ren.
            if (r_state == RD_WAIT) begin
                if (r_rd_mem) begin
                    r_rdata <= mem_rdata;
                    r_rresp <= RESP_OKAY;
                end else if (reg_mapped(r_rd_ofs, CYCLE_EN)) begin
                    r_rdata <= w_reg_rdata;
                    r_rresp <= RESP_OKAY;
                end else begin
                    r_rdata <= '0;
                    r_rresp <= RESP_SLVERR;
                end
            end
        end
    end

    mips_cpu_rst_sync u_rst_sync (
        .clk            (mips_cpu_clk),
        .rst_n          (mips_cpu_reset_n),
        .i_core_rst     (r_core_rst),
        .o_core_reset_n (core_reset_n)
    );

endmodule

// File: tb/tb_mips_cpu_axi_bridge.sv
// Self-checking bench for mips_cpu_axi_bridge: directed register/memory cases plus a random
// transaction mix checked against a byte-level memory model and a CTRL register model.
module tb_mips_cpu_axi_bridge;

    localparam int          ADDR_W   = 14;
    localparam logic [13:0] REG_BASE = 14'h2000;
`ifdef MIPS_CPU_AXI_BRIDGE_PERF_CNT_EN
    localparam bit          HAS_CYCLE = 1'b1;
`else
    localparam bit          HAS_CYCLE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [13:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [10:0] mem_addr;
    logic        mem_wen;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ren;
    logic [31:0] mem_rdata = '0;
    logic        core_reset_n;

    always #5 clk = ~clk;

    mips_cpu_axi_bridge #(.ADDR_W(ADDR_W), .CORE_RST_INIT(1'b1)) dut (
        .mips_cpu_clk     (clk),
        .mips_cpu_reset_n (rst_n),
        .s_awaddr         (awaddr),
        .s_awvalid        (awvalid),
        .s_awready        (awready),
        .s_wdata          (wdata),
        .s_wstrb          (wstrb),
        .s_wvalid         (wvalid),
        .s_wready         (wready),
        .s_bresp          (bresp),
        .s_bvalid         (bvalid),
        .s_bready         (bready),
        .s_araddr         (araddr),
        .s_arvalid        (arvalid),
        .s_arready        (arready),
        .s_rdata          (rdata),
        .s_rresp          (rresp),
        .s_rvalid         (rvalid),
        .s_rready         (rready),
        .mem_addr         (mem_addr),
        .mem_wen          (mem_wen),
        .mem_wstrb        (mem_wstrb),
        .mem_wdata        (mem_wdata),
        .mem_ren          (mem_ren),
        .mem_rdata        (mem_rdata),
        .core_reset_n     (core_reset_n)
    );

    // CPU memory: synchronous read, one cycle latency, byte-enable writes.
    logic [31:0] ram [0:2047] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= ram[mem_addr];
        if (mem_wen) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model: byte-addressed memory and the CTRL.core_rst bit.
    logic [7:0] exp_b [0:8191] = '{default: 8'h0};
    logic       exp_ctrl = 1'b1;

    int total = 0;
    int bad   = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int hs_edge = -100;
    int rise_cyc = -1;
    int wen_cnt = 0;
    int ren_cnt = 0;
    logic prev_crn = 1'b0;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (awready) hs_edge = cyc + 1;
        if (core_reset_n && !prev_crn) rise_cyc = cyc;
        prev_crn = core_reset_n;
        if (mem_wen) wen_cnt++;
        if (mem_ren) ren_cnt++;
    end

    function automatic logic [31:0] model_word(input int word);
        return {exp_b[word*4+3], exp_b[word*4+2], exp_b[word*4+1], exp_b[word*4]};
    endfunction

    task automatic model_write(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int word;
        int ofs;
        if (addr[13] == 1'b0) begin
            word = int'(addr) / 4;
            for (int b = 0; b < 4; b++)
                if (strb[b]) exp_b[word*4+b] = data[8*b +: 8];
        end else begin
            ofs = int'(addr) - int'(REG_BASE);
            if (ofs < 4 && strb[0]) exp_ctrl = data[0];
        end
    endtask

    function automatic logic [1:0] model_resp(input logic [13:0] addr);
        int ofs;
        if (addr[13] == 1'b0) return 2'b00;
        ofs = int'(addr) - int'(REG_BASE);
        if (ofs < 4) return 2'b00;
        if (HAS_CYCLE && ofs >= 4 && ofs < 8) return 2'b00;
        return 2'b10;
    endfunction

    task automatic axi_wr(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output int lat, output logic hs_wen,
                          output logic [10:0] hs_maddr, output logic [3:0] hs_strb,
                          output logic [31:0] hs_wdata);
        int n;
        @(posedge clk); #1;
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 20) begin n++; @(negedge clk); end
        chk_val("wr_handshake", {30'b0, awready, wready}, 32'h3);
        hs_wen = mem_wen; hs_maddr = mem_addr; hs_strb = mem_wstrb; hs_wdata = mem_wdata;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bvalid && lat < 20) begin lat++; @(negedge clk); end
        resp = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [13:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp, output int lat,
                          output logic hs_ren, output logic [10:0] hs_maddr, output logic stable);
        int n;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin n++; @(negedge clk); end
        chk_val("rd_handshake", {31'b0, arready}, 32'h1);
        hs_ren = mem_ren; hs_maddr = mem_addr;
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rvalid && lat < 20) begin lat++; @(negedge clk); end
        data = rdata; resp = rresp; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rvalid || rdata !== data || rresp !== resp) stable = 1'b0;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] data;
        logic [10:0] maddr;
        logic [3:0]  mstrb;
        logic [31:0] mwd;
        logic        hs;
        logic        stable;
        int          lat;
        int          wcnt0;
        int          n;
        logic [13:0] a;
        logic [31:0] d;
        logic [3:0]  s;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_val("rst_core_reset_n", {31'b0, core_reset_n}, 32'h0);
        chk_val("rst_valids", {28'b0, bvalid, rvalid, awready, arready}, 32'h0);
        chk_val("rst_rdata", rdata, 32'h0);
        chk_val("rst_resps", {28'b0, bresp, rresp}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // CTRL reset value
        axi_rd(REG_BASE, 0, data, resp, lat, hs, maddr, stable);
        chk_val("ctrl_init_data", data, 32'h1);
        chk_val("ctrl_init_resp", {30'b0, resp}, 32'h0);
        chk_val("ctrl_init_lat", 32'(lat), 32'd2);
        chk_val("ctrl_init_no_ren", {31'b0, hs}, 32'h0);
        chk_val("core_held_in_reset", {31'b0, core_reset_n}, 32'h0);

        // Releasing the core: core_reset_n rises 2 edges after the write handshake edge
        wcnt0 = wen_cnt;
        axi_wr(REG_BASE, 32'h0, 4'hF, resp, lat, hs, maddr, mstrb, mwd);
        model_write(REG_BASE, 32'h0, 4'hF);
        chk_val("ctrl_wr_resp", {30'b0, resp}, 32'h0);
        chk_val("ctrl_wr_lat", 32'(lat), 32'd1);
        chk_val("ctrl_wr_no_wen", 32'(wen_cnt - wcnt0), 32'd0);
        repeat (3) @(negedge clk);
        chk_val("core_rst_release_delay", 32'(rise_cyc - hs_edge), 32'd2);
        chk_val("core_running", {31'b0, core_reset_n}, 32'h1);

        // Partial-strobe memory write then read back
        wcnt0 = wen_cnt;
        axi_wr(14'h0010, 32'hDEADBEEF, 4'b0011, resp, lat, hs, maddr, mstrb, mwd);
        model_write(14'h0010, 32'hDEADBEEF, 4'b0011);
        chk_val("mem_wr_resp", {30'b0, resp}, 32'h0);
        chk_val("mem_wr_wen", {31'b0, hs}, 32'h1);
        chk_val("mem_wr_addr", {21'b0, maddr}, 32'd4);
        chk_val("mem_wr_strb", {28'b0, mstrb}, 32'h3);
        chk_val("mem_wr_data", mwd, 32'hDEADBEEF);
        chk_val("mem_wr_wen_pulses", 32'(wen_cnt - wcnt0), 32'd1);
        axi_rd(14'h0010, 0, data, resp, lat, hs, maddr, stable);
        chk_val("mem_rd_lat", 32'(lat), 32'd2);
        chk_val("mem_rd_ren", {31'b0, hs}, 32'h1);
        chk_val("mem_rd_addr", {21'b0, maddr}, 32'd4);
        chk_val("mem_rd_data", data, model_word(4));
        chk_val("mem_rd_data_abs", data, 32'h0000BEEF);

        // Write pair and read presented together: write wins, read follows bready
        @(posedge clk); #1;
        awaddr = 14'h0020; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 14'h0010; arvalid = 1'b1;
        @(negedge clk);
        chk_val("prio_aw_first", {30'b0, awready, arready}, 32'h2);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(14'h0020, 32'h12345678, 4'hF);
        @(negedge clk);
        chk_val("prio_bvalid", {31'b0, bvalid}, 32'h1);
        chk_val("prio_ar_blocked", {31'b0, arready}, 32'h0);
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        chk_val("prio_ar_after_b", {31'b0, arready}, 32'h1);
        @(posedge clk); #1 arvalid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!rvalid && n < 20) begin n++; @(negedge clk); end
        chk_val("prio_rd_lat", 32'(n), 32'd2);
        chk_val("prio_rd_data", rdata, model_word(4));
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        @(negedge clk);
        chk_val("rvalid_drops", {31'b0, rvalid}, 32'h0);

        // Unmapped register read with back-pressure
        axi_rd(REG_BASE | 14'h0008, 5, data, resp, lat, hs, maddr, stable);
        chk_val("unmapped_rd_resp", {30'b0, resp}, 32'h2);
        chk_val("unmapped_rd_data", data, 32'h0);
        chk_val("unmapped_rd_stable", {31'b0, stable}, 32'h1);
        axi_wr(REG_BASE | 14'h000C, 32'h1, 4'hF, resp, lat, hs, maddr, mstrb, mwd);
        chk_val("unmapped_wr_resp", {30'b0, resp}, 32'h2);
        axi_rd(REG_BASE, 0, data, resp, lat, hs, maddr, stable);
        chk_val("ctrl_untouched", data, {31'b0, exp_ctrl});

        axi_rd(REG_BASE | 14'h0004, 0, data, resp, lat, hs, maddr, stable);
`ifdef MIPS_CPU_AXI_BRIDGE_PERF_CNT_EN
        chk_val("cycle_resp", {30'b0, resp}, 32'h0);
        axi_wr(REG_BASE, 32'h1, 4'hF, resp, lat, hs, maddr, mstrb, mwd);
        model_write(REG_BASE, 32'h1, 4'hF);
        repeat (4) @(posedge clk);
        axi_wr(REG_BASE, 32'h0, 4'hF, resp, lat, hs, maddr, mstrb, mwd);
        model_write(REG_BASE, 32'h0, 4'hF);
        repeat (10) @(posedge clk);
        axi_rd(REG_BASE | 14'h0004, 0, data, resp, lat, hs, maddr, stable);
        chk_val("cycle_in_range", {31'b0, (data >= 32'd10 && data <= 32'd13)}, 32'h1);
`else
        chk_val("cycle_absent_resp", {30'b0, resp}, 32'h2);
        chk_val("cycle_absent_data", data, 32'h0);
`endif

        // Reset asserted while a read waits on memory: transaction is dropped
        @(posedge clk); #1;
        araddr = 14'h0010; arvalid = 1'b1;
        @(negedge clk);
        chk_val("midrst_ar", {31'b0, arready}, 32'h1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_val("midrst_rvalid", {31'b0, rvalid}, 32'h0);
        chk_val("midrst_rdata", rdata, 32'h0);
        chk_val("midrst_core", {31'b0, core_reset_n}, 32'h0);
        exp_ctrl = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        repeat (8) begin @(negedge clk); if (rvalid || bvalid) n++; end
        chk_val("midrst_no_response", 32'(n), 32'd0);
        axi_rd(REG_BASE, 0, data, resp, lat, hs, maddr, stable);
        chk_val("midrst_ctrl_reinit", data, 32'h1);

        // Random mix against the reference model
        for (int t = 0; t < 80; t++) begin
            int kind;
            int word;
            kind = int'($urandom_range(0, 9));
            word = int'($urandom_range(0, 63));
            if (kind <= 6) a = 14'(word * 4 + int'($urandom_range(0, 3)));
            else begin
                case ($urandom_range(0, 3))
                    0:       a = REG_BASE;
                    1:       a = REG_BASE | 14'h0004;
                    2:       a = REG_BASE | 14'h0008;
                    default: a = REG_BASE | 14'(4 * $urandom_range(3, 255));
                endcase
            end
            d = $urandom;
            s = (kind <= 3) ? 4'($urandom_range(0, 15)) : 4'hF;
            if (kind <= 3 || kind == 7) begin
                wcnt0 = wen_cnt;
                axi_wr(a, d, s, resp, lat, hs, maddr, mstrb, mwd);
                chk_val("rnd_wr_resp", {30'b0, resp}, {30'b0, model_resp(a)});
                chk_val("rnd_wr_lat", 32'(lat), 32'd1);
                chk_val("rnd_wr_wen", 32'(wen_cnt - wcnt0), (a[13] == 1'b0) ? 32'd1 : 32'd0);
                if (a[13] == 1'b0) begin
                    chk_val("rnd_wr_addr", {21'b0, maddr}, 32'(int'(a) / 4));
                    chk_val("rnd_wr_strb", {28'b0, mstrb}, {28'b0, s});
                end
                model_write(a, d, s);
            end else begin
                axi_rd(a, int'($urandom_range(0, 3)), data, resp, lat, hs, maddr, stable);
                chk_val("rnd_rd_resp", {30'b0, resp}, {30'b0, model_resp(a)});
                chk_val("rnd_rd_lat", 32'(lat), 32'd2);
                chk_val("rnd_rd_stable", {31'b0, stable}, 32'h1);
                chk_val("rnd_rd_ren", {31'b0, hs}, {31'b0, ~a[13]});
                if (a[13] == 1'b0) begin
                    chk_val("rnd_rd_addr", {21'b0, maddr}, 32'(int'(a) / 4));
                    chk_val("rnd_rd_mem", data, model_word(int'(a) / 4));
                end else if (int'(a) - int'(REG_BASE) < 4) begin
                    chk_val("rnd_rd_ctrl", data, {31'b0, exp_ctrl});
                end else if (model_resp(a) == 2'b10) begin
                    chk_val("rnd_rd_err_data", data, 32'h0);
                end
            end
        end
        repeat (3) @(negedge clk);
        chk_val("final_core_reset_n", {31'b0, core_reset_n}, {31'b0, ~exp_ctrl});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
